wb_queue: RTL
=============

# wb_queue

Write-back queue that sits between the execute/load result producers and the 4x32 register file's single write port. It buffers up to DEPTH pending register writes, drains one per cycle onto the register file's RegWrite/WriteReg/WriteData inputs, and back-pressures producers when full. It also provides two forwarding lookups, so operand reads see the youngest pending value before it reaches the register file.

## Interface
- DEPTH, 4, queue entries; power of 2, at least 2
- AW, 2, register address width; matches the register file's WriteReg/ReadReg width
- DW, 32, data width

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; reset=0 at a rising edge clears all state
- in_valid  in  1  producer has a result
- in_ready  out  1  queue can accept this cycle
- in_reg  in  AW  destination register
- in_data  in  DW  result value
- wb_stall  in  1  1 = do not pop this cycle (write port busy)
- RegWrite  out  1  registered write enable to the register file
- WriteReg  out  AW  registered write address
- WriteData  out  DW  registered write data
- fwd_addr1, fwd_addr2  in  AW  lookup addresses (ReadReg1/ReadReg2)
- fwd_hit1, fwd_hit2  out  1  a pending write to that address exists
- fwd_data1, fwd_data2  out  DW  youngest pending value for that address; 0 when there is no hit
- count  out  clog2(DEPTH)+1  entries held in the queue, excluding the output stage

## Operation
- Storage: circular buffer of DEPTH {reg, data} slots with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- Enqueue: occurs at a rising edge when in_valid & in_ready. Slot[wr_ptr] is loaded and wr_ptr advances.
- Pop condition: pop = (count != 0) & !wb_stall.
- Pop action: head entry moves into the output stage (RegWrite=1, WriteReg, WriteData) and rd_ptr advances.
- No pop:
  - RegWrite=0 on the next cycle.
  - WriteReg/WriteData hold their last value.
- in_ready = (count < DEPTH) | pop. This is combinational from count and wb_stall. When full, accept and pop in the same cycle are legal.
- count update:
  - +1 on enqueue only
  - −1 on pop only
  - unchanged on both or on neither
- Ordering: strictly FIFO. Writes to the same register retire in arrival order.
- Forwarding (combinational, per lookup port):
  - Candidates are all valid queue entries plus the output stage when RegWrite=1.
  - Priority, youngest first: newest queue entry (wr_ptr−1) back to the head, then the output stage.
  - in_valid data of the current cycle is not forwarded.
  - On a miss: hit=0, data=0.
- Producers must hold in_valid/in_reg/in_data stable until accepted.

## Timing
- Reset (reset=0 at an edge) sets:
  - count=0, wr_ptr=rd_ptr=0
  - RegWrite=0, WriteReg=0, WriteData=0
  - fwd_hit*=0
- Reset in the middle of operation discards every pending write, including one in the output stage. in_valid is ignored at a reset edge.
- Latency into an empty, unstalled queue:
  - enqueue at edge k
  - pop at edge k+1
  - RegWrite=1 between edges k+1 and k+2
  - the register file captures the write at edge k+2
- Throughput: one write per cycle sustained with wb_stall=0. The queue never fills.
- wb_stall=1: count grows by one per accepted input until DEPTH. in_ready then falls to 0.
- Full (count=DEPTH) with wb_stall=0: in_ready=1; enqueue and pop occur together and count stays at DEPTH.
- Empty (count=0): pop is 0 regardless of wb_stall.

## Test plan
- Reset then single write:
  - Stimulus: reset=0 for 2 cycles, then reset=1; enqueue {reg 2, 32'hBFAFAFAF}.
  - Response: RegWrite=1, WriteReg=2, WriteData=BFAFAFAF for exactly one cycle, 2 edges after acceptance; count returns to 0.
- Fill under stall:
  - Stimulus: wb_stall=1; offer 5 writes {reg0..reg3, reg1}.
  - Response: first 4 accepted; count=4; in_ready=0 for the 5th.
  - Stimulus: release wb_stall.
  - Response: RegWrite pulses reg0, reg1, reg2, reg3, reg1 in order on consecutive cycles.
- Full with simultaneous push/pop:
  - Stimulus: count=4, wb_stall=0, in_valid=1.
  - Response: in_ready=1; count stays 4; no entry lost.
- Forwarding priority:
  - Stimulus: queue holds {reg1, 32'h11}, {reg1, 32'h22}, stalled; fwd_addr1=1, fwd_addr2=3.
  - Response: fwd_hit1=1, fwd_data1=22; fwd_hit2=0, fwd_data2=0.
  - Stimulus: drain until only the output stage holds reg1.
  - Response: fwd_data1=22 while RegWrite=1.
- Reset mid-operation:
  - Stimulus: 3 entries queued, stalled; assert reset=0 for one edge.
  - Response: count=0, RegWrite=0, no write ever issued for those entries.
- Pointer wrap:
  - Stimulus: stream 10 writes with alternating wb_stall.
  - Response: all 10 retire in order with correct data across pointer wrap-around.

Source files
------------

// File: rtl/wb_queue.sv
// Write-back queue: buffers pending register-file writes, drains one per cycle
// through a registered output stage, and forwards the youngest pending value.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_reg,
    input  logic [DW-1:0]              in_data,
    input  logic                       wb_stall,
    output logic                       RegWrite,
    output logic [AW-1:0]              WriteReg,
    output logic [DW-1:0]              WriteData,
    input  logic [AW-1:0]              fwd_addr1,
    input  logic [AW-1:0]              fwd_addr2,
    output logic                       fwd_hit1,
    output logic                       fwd_hit2,
    output logic [DW-1:0]              fwd_data1,
    output logic [DW-1:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] slotReg  [DEPTH];
    logic [DW-1:0] slotData [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] countReg;
    logic          pop;
    logic          push;

    assign pop      = (countReg != '0) && !wb_stall;
    assign in_ready = (countReg < CW'(DEPTH)) || pop;
    assign push     = in_valid && in_ready;
    assign count    = countReg;

    // Slot contents need no reset: countReg alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push && reset) begin
            slotReg[wrPtr]  <= in_reg;
            slotData[wrPtr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            countReg  <= '0;
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                RegWrite  <= 1'b1;
                WriteReg  <= slotReg[rdPtr];
                WriteData <= slotData[rdPtr];
                rdPtr     <= rdPtr + 1'b1;
            end else begin
                RegWrite <= 1'b0;
            end
            if (push && !pop) begin
                countReg <= countReg + 1'b1;
            end else if (pop && !push) begin
                countReg <= countReg - 1'b1;
            end
        end
    end

    logic [AW-1:0] fwdAddr [2];
    assign fwdAddr[0] = fwd_addr1;
    assign fwdAddr[1] = fwd_addr2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gFwd
            logic          hit;
            logic [DW-1:0] data;
            // Scan oldest to newest so the youngest matching entry wins;
            // the output stage is the oldest candidate of all.
            always_comb begin
                hit  = 1'b0;
                data = '0;
                if (RegWrite && (WriteReg == fwdAddr[gi])) begin
                    hit  = 1'b1;
                    data = WriteData;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if ((CW'(i) < countReg) &&
                        (slotReg[rdPtr + PW'(i)] == fwdAddr[gi])) begin
                        hit  = 1'b1;
                        data = slotData[rdPtr + PW'(i)];
                    end
                end
            end
        end
    endgenerate

    assign fwd_hit1  = gFwd[0].hit;
    assign fwd_data1 = gFwd[0].data;
    assign fwd_hit2  = gFwd[1].hit;
    assign fwd_data2 = gFwd[1].data;
endmodule
